// File: rtl/if_bus_ctrl.sv
// Instruction-fetch bus master feeding the IF pipeline register.
// Optional ACCESS timeout is built when IF_BUS_TIMEOUT_EN is defined.
module if_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int WORD_ADDR_W = 30,
  localparam int WORD_DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic                   as_,
  output logic [WORD_DATA_W-1:0] insn,
  output logic                   busy,
  output logic                   bus_err,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_
);

  localparam logic READ = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    STALL
  } state_t;

  state_t                 state, state_n;
  logic                   req_n, as_n;
  logic [WORD_ADDR_W-1:0] addr_n;
  logic [WORD_DATA_W-1:0] hold, hold_n;
  logic                   drop, drop_n;
  logic                   tmo;

  assign bus_rw  = READ;
  assign bus_err = tmo;

`ifdef IF_BUS_TIMEOUT_EN
  logic [7:0] cnt;

  assign tmo = (state == ACCESS) && bus_rdy_ &&
               (cnt == 8'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared on ACCESS entry and on timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state == REQ && !bus_grnt_)
      cnt <= '0;
    else if (tmo)
      cnt <= '0;
    else if (state == ACCESS && bus_rdy_)
      cnt <= cnt + 8'd1;
  end
`else
  logic [7:0] unused_to;

  assign unused_to = 8'(TIMEOUT_CYCLES);
  assign tmo       = 1'b0;
`endif

  // State and registered bus-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bus_req_ <= 1'b1;
      bus_as_  <= 1'b1;
      bus_addr <= '0;
      hold     <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_n;
      bus_req_ <= req_n;
      bus_as_  <= as_n;
      bus_addr <= addr_n;
      hold     <= hold_n;
      drop     <= drop_n;
    end
  end

  // Next-state, next bus values and fetch-side outputs
  always_comb begin
    state_n = state;
    req_n   = bus_req_;
    as_n    = 1'b1;
    addr_n  = bus_addr;
    hold_n  = hold;
    drop_n  = drop;
    insn    = '0;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!as_ && !flush) begin
          state_n = REQ;
          req_n   = 1'b0;
          addr_n  = addr;
          busy    = 1'b1;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (flush)
          drop_n = 1'b1;
        if (!bus_grnt_) begin
          state_n = ACCESS;
          as_n    = 1'b0;
        end
      end
      ACCESS: begin
        if (!bus_rdy_) begin
          insn    = (drop || flush) ? '0 : bus_rd_data;
          hold_n  = (drop || flush) ? '0 : bus_rd_data;
          drop_n  = 1'b0;
          req_n   = 1'b1;
          state_n = stall ? STALL : IDLE;
        end else if (tmo) begin
          drop_n  = 1'b0;
          req_n   = 1'b1;
          state_n = IDLE;
        end else begin
          busy = 1'b1;
          if (flush)
            drop_n = 1'b1;
        end
      end
      STALL: begin
        insn = hold;
        if (!stall || flush)
          state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_if_bus_ctrl.sv
// Directed bench for if_bus_ctrl with an expected-instruction queue.
// Timeout steps run when IF_BUS_TIMEOUT_EN is defined.
module tb_if_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [29:0] addr;
  logic        as_;
  logic [31:0] insn;
  logic        busy;
  logic        bus_err;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  if_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .addr(addr),
    .as_(as_),
    .insn(insn),
    .busy(busy),
    .bus_err(bus_err),
    .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_),
    .bus_addr(bus_addr),
    .bus_as_(bus_as_),
    .bus_rw(bus_rw),
    .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch: grant after gdly REQ cycles, ready after rdly ACCESS
  // cycles, stl STALL cycles, fl = flush pulse in first ACCESS cycle.
  task automatic fetch(input logic [29:0] a, input logic [31:0] d,
                       input int gdly, input int rdly, input int stl,
                       input logic fl);
    logic [31:0] got;
    sb.push_back(fl ? 32'h0 : d);
    as_ = 1'b0; addr = a; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1);
    tick();
    as_ = 1'b1;
    addr = ~a;
    for (int i = 0; i <= gdly; i++) begin
      bus_grnt_ = (i == gdly) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk("req_busy", busy, 1);
      chk("req_req", bus_req_, 0);
      chk("req_addr", bus_addr, a);
      chk("req_insn", insn, 0);
      tick();
    end
    bus_grnt_ = 1'b1;
    stall = (stl > 0);
    got = '0;
    for (int n = 0; n <= rdly; n++) begin
      bus_rdy_ = (n == rdly) ? 1'b0 : 1'b1;
      bus_rd_data = (n == rdly) ? d : 32'hdead_beef;
      flush = fl && (n == 0);
      @(negedge clk);
      chk("acc_as", bus_as_, (n == 0) ? 1'b0 : 1'b1);
      chk("acc_addr", bus_addr, a);
      chk("acc_req", bus_req_, 0);
      if (n < rdly) begin
        chk("acc_busy", busy, 1);
        chk("acc_insn", insn, 0);
        tick();
      end else begin
        chk("done_busy", busy, 0);
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          chk("done_insn", insn, got);
        end
      end
    end
    flush = 1'b0;
    for (int k = 0; k < stl; k++) begin
      tick();
      bus_rdy_ = 1'b1;
      bus_rd_data = 32'hdead_beef;
      if (k == stl - 1)
        stall = 1'b0;
      @(negedge clk);
      chk("stall_insn", insn, got);
      chk("stall_busy", busy, 0);
    end
    tick();
    stall = 1'b0;
    bus_rdy_ = 1'b1;
    bus_rd_data = 32'hdead_beef;
    @(negedge clk);
    chk("post_req", bus_req_, 1);
    chk("post_as", bus_as_, 1);
    chk("post_busy", busy, 0);
    chk("post_insn", insn, 0);
    chk("post_err", bus_err, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; addr = '0; as_ = 1'b1;
    bus_grnt_ = 1'b1; bus_rd_data = '0; bus_rdy_ = 1'b1;
    @(negedge clk);
    chk("rst_req", bus_req_, 1);
    chk("rst_as", bus_as_, 1);
    chk("rst_addr", bus_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_insn", insn, 0);
    chk("rst_err", bus_err, 0);
    chk("rw_read", bus_rw, 1);
    tick();
    reset = 1'b0;
    tick();

    // Reset pulse while a request is pending
    as_ = 1'b0; addr = 30'h99;
    @(negedge clk);
    chk("mid_idle_busy", busy, 1);
    tick();
    as_ = 1'b1;
    @(negedge clk);
    chk("mid_req", bus_req_, 0);
    chk("mid_addr", bus_addr, 30'h99);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("mid_async_req", bus_req_, 1);
    tick();
    @(negedge clk);
    chk("mid_rst_req", bus_req_, 1);
    chk("mid_rst_as", bus_as_, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_insn", insn, 0);
    chk("mid_rst_addr", bus_addr, 0);
    tick();

    // Minimum-latency fetch
    fetch(30'h99, 32'h1, 0, 0, 0, 1'b0);
    // Delayed grant and ready
    fetch(30'h1234, 32'h2, 4, 2, 0, 1'b0);
    // Stall held across completion
    fetch(30'h55, 32'h3, 0, 0, 5, 1'b0);
    // Flush during ACCESS drops the data
    fetch(30'h77, 32'h4, 1, 2, 0, 1'b1);
    // Drop flag must not leak into the next fetch
    fetch(30'h3fff_ffff, 32'hcafe_f00d, 0, 1, 0, 1'b0);

    // Flush wins over a request in IDLE
    as_ = 1'b0; flush = 1'b1; addr = 30'h11;
    @(negedge clk);
    chk("flidle_busy", busy, 0);
    tick();
    as_ = 1'b1; flush = 1'b0;
    @(negedge clk);
    chk("flidle_req", bus_req_, 1);
    chk("flidle_busy2", busy, 0);
    tick();

`ifdef IF_BUS_TIMEOUT_EN
    // Slave never answers: abort after four ACCESS cycles
    sb.push_back(32'h0);
    as_ = 1'b0; addr = 30'h42;
    @(negedge clk);
    tick();
    as_ = 1'b1; bus_grnt_ = 1'b0;
    @(negedge clk);
    tick();
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n < 4) begin
        chk("to_wait_err", bus_err, 0);
        chk("to_wait_busy", busy, 1);
      end else begin
        chk("to_err", bus_err, 1);
        chk("to_busy", busy, 0);
        chk("sb_to_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0)
          chk("to_insn", insn, sb.pop_front());
      end
      tick();
    end
    @(negedge clk);
    chk("to_req", bus_req_, 1);
    chk("to_err_clr", bus_err, 0);
    chk("to_busy_clr", busy, 0);
    tick();
    fetch(30'h43, 32'h5, 0, 3, 0, 1'b0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_bus_ctrl.md
# if_bus_ctrl

Instruction-fetch bus master sitting directly upstream of the IF pipeline register. It takes the fetch address (current `if_pc`) from the IF stage and arbitrates for the shared bus. It runs a read transaction and returns the fetched word on `insn`, which feeds the IF register's instruction input. It asserts `busy` to stall the pipeline while a fetch is outstanding, and honours pipeline `stall` and `flush`.

## Interface
- `TIMEOUT_CYCLES`, 255: ACCESS-state cycles without `bus_rdy_` before abort; only used with `IF_BUS_TIMEOUT_EN`; 8-bit counter, legal 1..255.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high (`RESET_ENABLE`); one clock domain only.
- `stall`  in  1  pipeline stall; holds a completed fetch.
- `flush`  in  1  pipeline flush; fetched data is discarded (NOP = `WORD_DATA_W'h0`).
- `addr`  in  `WORD_ADDR_W` (30)  fetch word address.
- `as_`  in  1  active-low fetch request from IF.
- `insn`  out  `WORD_DATA_W` (32)  fetched instruction to IF register.
- `busy`  out  1  fetch outstanding; pipeline must stall.
- `bus_err`  out  1  one-cycle timeout pulse.
- `bus_req_`  out  1  active-low bus request to arbiter.
- `bus_grnt_`  in  1  active-low grant.
- `bus_addr`  out  `WORD_ADDR_W`  bus address.
- `bus_as_`  out  1  active-low address strobe.
- `bus_rw`  out  1  tied to `READ`.
- `bus_rd_data`  in  `WORD_DATA_W`  read data.
- `bus_rdy_`  in  1  active-low slave ready.

## Operation
- States: IDLE, REQ, ACCESS, STALL.
- IDLE:
  - `as_`=0 and `flush`=0: latch `addr` into `bus_addr`, assert `bus_req_`, and go to REQ.
  - Otherwise stay in IDLE.
- REQ: hold `bus_req_`=0. On `bus_grnt_`=0, drive `bus_as_`=0 for exactly one cycle and go to ACCESS.
- ACCESS: `bus_req_` stays 0, `bus_as_`=1. On `bus_rdy_`=0, capture `bus_rd_data` into the hold register.
  - If `stall`=1, go to STALL.
  - Otherwise go to IDLE and release `bus_req_`.
- STALL: `insn` = hold register. Go to IDLE when `stall`=0 or `flush`=1.
- `busy` (combinational):
  - IDLE with `as_`=0 and `flush`=0.
  - REQ.
  - ACCESS with `bus_rdy_`=1.
- `insn` (combinational):
  - `bus_rd_data` in ACCESS when `bus_rdy_`=0.
  - Hold register in STALL.
  - `WORD_DATA_W'h0` otherwise.
- Flush during REQ/ACCESS: the bus transaction is never aborted. The drop flag is set, and on completion `insn` is forced to 0 and the flag clears.
- `flush` has priority over `as_` in IDLE.

## Timing
- Reset values: state IDLE, `bus_req_`=1, `bus_as_`=1, `bus_addr`=0, hold=0, drop=0, counter=0, `bus_err`=0, `insn`=0, `busy`=0.
- Reset asserted mid-transaction returns to IDLE immediately and releases the bus; data is lost.
- Minimum latency, `as_` low to `insn` valid: 3 cycles when grant and ready are immediate (IDLE→REQ→ACCESS, data in the ACCESS cycle with `bus_rdy_`=0).
- `busy` falls in the same cycle `insn` is valid.
- `bus_addr` is stable from REQ entry until return to IDLE.
- Back-to-back fetches: the IDLE cycle between transactions is mandatory.

## Configuration
- `IF_BUS_TIMEOUT_EN` defined: an 8-bit counter increments each ACCESS cycle with `bus_rdy_`=1.
  - When it reaches `TIMEOUT_CYCLES`, go to IDLE, release `bus_req_`, drive `insn`=0 and `busy`=0 that cycle, pulse `bus_err`=1 for one cycle, and clear the counter.
  - The counter also clears on every ACCESS entry.
- Undefined: ACCESS waits indefinitely, no counter is built, and `bus_err` is tied 0 (port retained).

## Test plan
- Reset pulse mid-REQ (`addr`=0x99 pending) → next edge: `bus_req_`=1, `bus_as_`=1, `busy`=0, `insn`=0.
- `as_`=0, `addr`=0x99, immediate grant, ready with data 0x1 → `bus_as_` low one cycle with `bus_addr`=0x99; `insn`=0x1 and `busy`=0 on the 3rd cycle.
- Grant delayed 4 cycles, ready delayed 2 → `busy` high throughout; `insn`=0x2 only in the ready cycle.
- `stall`=1 when ready returns 0x3 → `insn` holds 0x3 for 5 stall cycles; IDLE the cycle after `stall` drops.
- `flush` pulse during ACCESS, data 0x4 → bus completes normally; `insn`=0 on completion. `flush` and `as_`=0 together in IDLE → no request.
- `IF_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `bus_rdy_` never asserted → `bus_err` pulses in the 4th ACCESS cycle, `busy` drops, `bus_req_` released.
